// File: rtl/arb_rr4.sv
// Four-way arbiter with a registered one-hot grant, bounded hold time and a one-cycle bus-turnaround gap.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 > 3.
module arb_rr4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [3:0]       gnt_r, gnt_nxt_s;
  logic [1:0]       gnt_idx_r, gnt_idx_nxt_s;
  logic             gnt_valid_r, gnt_valid_nxt_s;
  logic             timeout_r, timeout_nxt_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic [1:0]       last_r, last_nxt_s;
  logic [1:0]       winner_s;
  logic             hold_done_s;
  logic             owner_req_s;

`ifdef ARB_FIXED_PRIO_EN
  // Lowest set request index wins; the pointer argument does not affect the result.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] win;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && r[k]) begin
        win   = k[1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction
`else
  // First set request scanning upward from the one after the previous winner, wrapping.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] win;
    logic [1:0] cand;
    logic       found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && r[cand]) begin
        win   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction
`endif

  assign winner_s    = pick_winner(req, last_r);
  assign hold_done_s = (hold_cnt_r == CNT_W'(MAX_HOLD - 1));
  assign owner_req_s = req[gnt_idx_r];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision; a dropped request takes precedence over the hold limit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s || hold_done_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_GAP: begin
        if (req != 4'b0000) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, hold counter and last-winner pointer.
  always_comb begin
    gnt_nxt_s       = gnt_r;
    gnt_idx_nxt_s   = gnt_idx_r;
    gnt_valid_nxt_s = gnt_valid_r;
    timeout_nxt_s   = 1'b0;
    hold_cnt_nxt_s  = hold_cnt_r;
    last_nxt_s      = last_r;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (req != 4'b0000) begin
          gnt_nxt_s       = 4'b0001 << winner_s;
          gnt_idx_nxt_s   = winner_s;
          gnt_valid_nxt_s = 1'b1;
          hold_cnt_nxt_s  = {CNT_W{1'b0}};
          last_nxt_s      = winner_s;
        end else begin
          gnt_nxt_s       = 4'b0000;
          gnt_valid_nxt_s = 1'b0;
          hold_cnt_nxt_s  = {CNT_W{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!owner_req_s) begin
          gnt_nxt_s       = 4'b0000;
          gnt_valid_nxt_s = 1'b0;
          hold_cnt_nxt_s  = {CNT_W{1'b0}};
        end else if (hold_done_s) begin
          gnt_nxt_s       = 4'b0000;
          gnt_valid_nxt_s = 1'b0;
          hold_cnt_nxt_s  = {CNT_W{1'b0}};
          timeout_nxt_s   = 1'b1;
        end else begin
          hold_cnt_nxt_s  = hold_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        gnt_nxt_s       = 4'b0000;
        gnt_valid_nxt_s = 1'b0;
        hold_cnt_nxt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= 4'b0000;
      gnt_idx_r   <= 2'b11;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      hold_cnt_r  <= {CNT_W{1'b0}};
      last_r      <= 2'b11;
    end else begin
      gnt_r       <= gnt_nxt_s;
      gnt_idx_r   <= gnt_idx_nxt_s;
      gnt_valid_r <= gnt_valid_nxt_s;
      timeout_r   <= timeout_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      last_r      <= last_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_arb_rr4.sv
// Scoreboard bench for arb_rr4: a cycle-level reference model pushes expected outputs, a monitor pops and compares.
module tb_arb_rr4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  arb_rr4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who holds the resource, for how many cycles so far, and who won last.
  int m_owner;
  int m_held;
  int m_last;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
  endtask

  function automatic int choose(input logic [3:0] r);
    int w;
    w = -1;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (r[k]) w = k;
`else
    for (int k = 4; k >= 1; k--) if (r[(m_last + k) % 4]) w = (m_last + k) % 4;
`endif
    return w;
  endfunction

  // Advance the model by one clock edge that samples r, and queue the outputs expected after it.
  task automatic step(input logic [3:0] r);
    exp_t e;
    logic to;
    to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) m_owner = -1;
      else if (m_held == MAX_HOLD) begin
        m_owner = -1;
        to = 1'b1;
      end else m_held++;
    end else if (r != 4'b0000) begin
      m_owner = choose(r);
      m_last  = m_owner;
      m_held  = 1;
    end
    e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.idx   = 2'(m_last);
    e.valid = (m_owner >= 0);
    e.to    = to;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    req = r;
    step(r);
  endtask

  task automatic drain_idle();
    for (int i = 0; i < 3; i++) cycle(4'b0000);
  endtask

  // Monitor: one expected entry per clock edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("gnt", {4'b0000, gnt}, {4'b0000, e.gnt});
        check("gnt_idx", {6'b000000, gnt_idx}, {6'b000000, e.idx});
        check("gnt_valid", {7'b0000000, gnt_valid}, {7'b0000000, e.valid});
        check("timeout", {7'b0000000, timeout}, {7'b0000000, e.to});
        check("gnt_onehot0", {7'b0000000, $onehot0(gnt)}, 8'd1);
      end
    end
  end

  initial begin
    logic [3:0] r;
    req   = 4'b1111;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_gnt", {4'b0000, gnt}, 8'h00);
    check("rst_idx", {6'b000000, gnt_idx}, 8'h03);
    check("rst_valid", {7'b0000000, gnt_valid}, 8'h00);
    check("rst_timeout", {7'b0000000, timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    step(4'b1111);
    cycle(4'b1111);
    drain_idle();

    // Single requester holding for three cycles.
    for (int i = 0; i < 3; i++) cycle(4'b0100);
    drain_idle();

    // Every grantee drops its request right after being granted.
    for (int i = 0; i < 14; i++) begin
      r = 4'b1111;
      if (m_owner >= 0) r[m_owner] = 1'b0;
      cycle(r);
    end
    drain_idle();

    // Two persistent requesters force timeouts in alternation.
    for (int i = 0; i < 40; i++) cycle(4'b0011);
    drain_idle();

    // Lone hog gets re-granted after each forced gap.
    for (int i = 0; i < 22; i++) cycle(4'b1000);
    drain_idle();

    // Asynchronous reset between edges while granted.
    for (int i = 0; i < 3; i++) cycle(4'b0110);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", {4'b0000, gnt}, 8'h00);
    check("async_rst_idx", {6'b000000, gnt_idx}, 8'h03);
    check("async_rst_valid", {7'b0000000, gnt_valid}, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    step(4'b1111);

    // Slowly toggling random requests: long holds, timeouts and handovers.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cycle(r);
    end
    // Fully random requests every cycle.
    for (int i = 0; i < 300; i++) cycle(4'($urandom));
    drain_idle();

    @(negedge clk);
    @(posedge clk);
    #2;
    check("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arb_rr4.md
Name: arb_rr4

Overview:
- Round-robin arbiter that shares one 4-way resource between four requesters.
- Output is a registered one-hot grant plus its 2-bit index. The index drives the 2-to-4 decoder select and downstream mux selects.
- Grant hold time is bounded. Forced release prevents one requester from starving the others.

Parameters:
- MAX_HOLD, 8: max consecutive GRANT cycles per grant before forced release; legal range 2..15.
- CNT_W, 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 4: request vector; bit i = requester i wants the resource; level-sensitive.
- gnt, output, 4: one-hot grant, registered; 4'b0000 when no grant.
- gnt_idx, output, 2: binary index of the granted requester; holds last value when gnt = 0.
- gnt_valid, output, 1: high iff gnt != 0.
- timeout, output, 1: one-cycle pulse on the cycle after a forced release.

Behaviour:
- Interface: one clock (clk); reset asynchronous and active-low (rst_n).
- Reset values: state = IDLE, gnt = 4'b0000, gnt_idx = 2'b11, gnt_valid = 0, timeout = 0, hold counter = 0, last pointer = 3.
- Reset deasserting mid-grant: arbiter restarts from IDLE; first search starts at requester 0.
- All outputs are registered; no combinational path from req to gnt.
- States: IDLE, GRANT, GAP.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise: pick a winner, go to GRANT.
  - gnt rises on the edge after req is sampled (latency 1 cycle).
- Winner selection: first set bit of req, scanning (last+1) mod 4, (last+2) mod 4, ... with wrap-around. On grant, last <= winner.
- GRANT:
  - Hold counter starts at 0 on entry and increments each cycle.
  - req[gnt_idx] == 0: go to GAP; gnt drops at that edge.
  - Else if counter == MAX_HOLD-1: forced release; go to GAP and pulse timeout in the GAP cycle.
  - Otherwise: stay in GRANT; gnt unchanged.
  - Changes on other req bits are ignored while in GRANT.
- GAP: exactly one cycle with gnt = 0 (bus turnaround).
  - req != 0: select a winner with the round-robin rule, go to GRANT.
  - Otherwise: go to IDLE.
  - After a forced release, last = the released index, so it is lowest priority next.
  - A lone requester that timed out is re-granted after the 1-cycle GAP.
- Invariant: gnt is always one-hot or zero, and gnt == (1 << gnt_idx) whenever gnt_valid = 1.
- Simultaneous events: the release and timeout conditions in the same cycle count as normal release (timeout stays 0).

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: winner selection is fixed priority 0 > 1 > 2 > 3; the last pointer is ignored. Forced release and GAP are unchanged, so a persistently requesting requester 0 still yields for one GAP cycle.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: rst_n = 0 with req = 4'b1111 -> gnt = 0000, gnt_idx = 11, timeout = 0. Release reset -> next edge gnt = 0001.
- Single request: req = 0100 for 3 cycles then 0000 -> gnt = 0100 one cycle after the request. gnt = 0000 on the edge that samples req = 0. Then 1 GAP cycle, then IDLE.
- Rotation: req = 1111, each grantee drops its bit one cycle after being granted -> grant order 0001, 0010, 0100, 1000, 0001, with one GAP cycle between grants.
- Timeout: MAX_HOLD = 8, req = 0011 held constant -> 0001 for 8 cycles, then GAP with timeout = 1. Next gnt = 0010 for 8 cycles, then gnt returns to 0001.
- Lone hog: req = 1000 constant -> 1000 for 8 cycles, 1 GAP cycle with timeout = 1, then 1000 again.
- Async reset mid-GRANT: rst_n low between edges -> gnt = 0000 immediately, without waiting for the next clk edge.
- ARB_FIXED_PRIO_EN build: req = 1111 with each grantee releasing after 1 cycle -> 0001 granted repeatedly and 0010 never, until req[0] = 0.
